// File: rtl/sal_ddr2_pkg.sv
// ---------------------------------------------------------------------------
// sal_ddr2_pkg
// Shared definitions for the per-bank DDR2 controller:
//   - bank_state_e : open/closed state of one bank
//   - cmd_e        : DRAM command a bank is currently requesting
//   - DDR2_*       : default DDR2-800 timing constants (in controller cycles)
// ---------------------------------------------------------------------------
package sal_ddr2_pkg;

    typedef enum logic {
        BK_CLOSED = 1'b0,
        BK_OPEN   = 1'b1
    } bank_state_e;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4
    } cmd_e;

    // Default DDR2-800 timing, expressed in controller clock cycles.
    localparam int DDR2_CNT_W = 5;
    localparam int DDR2_T_RCD = 5;   // ACT -> RD/WR
    localparam int DDR2_T_RP  = 5;   // PRE -> ACT
    localparam int DDR2_T_RAS = 18;  // ACT -> PRE
    localparam int DDR2_T_RTP = 3;   // RD  -> PRE
    localparam int DDR2_T_WTP = 13;  // WR  -> PRE (write latency + burst + tWR)

endpackage

// File: rtl/sal_timing_cnt.sv
// ---------------------------------------------------------------------------
// sal_timing_cnt
// Down-counter used to enforce one DRAM timing constraint. It is loaded with
// (T-1) on the grant of the command that starts the constraint, decrements
// once per cycle and holds at zero. zero=1 means the constraint is met.
//
// With MAX_LOAD=1 a load never shortens an outstanding wait: the register
// takes the larger of its current value and load_val. This lets several
// commands (reads and writes) share one counter toward the same PRE.
//
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset (counter -> 0)
//   load     in  load request (wins over decrement)
//   load_val in  value to load, normally T-1
//   zero     out counter is at zero
// ---------------------------------------------------------------------------
module sal_timing_cnt #(
    parameter int CNT_W    = 5,
    parameter bit MAX_LOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (MAX_LOAD && (cnt_q > load_val)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = load_val;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// ---------------------------------------------------------------------------
// sal_bank_ctrl
// Per-bank DRAM controller with an open-page policy. Holds one decoded
// request, tracks the bank's open row and DDR2 timing, and raises one of
// ACT/RD/WR/PRE toward the shared command scheduler.
//
// Handshakes:
//   req_*  : a request transfers on a clock edge where req_valid && req_ready.
//            req_ready depends only on internal state and rst (never on
//            req_valid or cmd_gnt), so a request is accepted at most every
//            second cycle.
//   cmd_*  : level requests, at most one high. The scheduler samples the
//            cmd_* fields in the cycle it asserts cmd_gnt; command and
//            fields stay stable until granted. cmd_gnt with no command
//            asserted is ignored.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake from the decoder
//   req_id/ra/ca/len/wr             request fields (wr=1 for writes)
//   cmd_act/rd/wr/pre               command requests to the scheduler
//   cmd_gnt                         grant for the asserted command
//   cmd_ra/ca/id/len                command fields (ra = open row for PRE)
//   ref_req                         refresh pending: bank must close
//   bk_idle                         bank closed and tRP satisfied
//   dbg_state                       current bank state (0=CLOSED, 1=OPEN)
//
// Timing parameters must lie in 1 .. 2**CNT_W-1.
// ---------------------------------------------------------------------------
module sal_bank_ctrl
    import sal_ddr2_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int RA_W  = 14,
    parameter int CA_W  = 10,
    parameter int LEN_W = 4,
    parameter int CNT_W = DDR2_CNT_W,
    parameter int T_RCD = DDR2_T_RCD,
    parameter int T_RP  = DDR2_T_RP,
    parameter int T_RAS = DDR2_T_RAS,
    parameter int T_RTP = DDR2_T_RTP,
    parameter int T_WTP = DDR2_T_WTP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    input  logic [RA_W-1:0]  req_ra,
    input  logic [CA_W-1:0]  req_ca,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_wr,
    output logic             cmd_act,
    output logic             cmd_rd,
    output logic             cmd_wr,
    output logic             cmd_pre,
    input  logic             cmd_gnt,
    output logic [RA_W-1:0]  cmd_ra,
    output logic [CA_W-1:0]  cmd_ca,
    output logic [ID_W-1:0]  cmd_id,
    output logic [LEN_W-1:0] cmd_len,
    input  logic             ref_req,
    output logic             bk_idle,
    output logic             dbg_state
);

    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] WTP_LD = CNT_W'(T_WTP - 1);

    // ------------------------------------------------------------------
    // State and request buffer
    // ------------------------------------------------------------------
    bank_state_e      state_d,    state_q;
    logic             pending_d,  pending_q;
    logic [ID_W-1:0]  buf_id_d,   buf_id_q;
    logic [RA_W-1:0]  buf_ra_d,   buf_ra_q;
    logic [CA_W-1:0]  buf_ca_d,   buf_ca_q;
    logic [LEN_W-1:0] buf_len_d,  buf_len_q;
    logic             buf_wr_d,   buf_wr_q;
    logic [RA_W-1:0]  open_row_d, open_row_q;

    // Timing counter status
    logic rcd_zero;
    logic ras_zero;
    logic pre_zero;
    logic rp_zero;

    // Decode results
    cmd_e             cmd_sel;
    logic             row_hit;
    logic             fire;
    logic             accept;
    logic             act_load;
    logic             col_load;
    logic             pre_load;
    logic [CNT_W-1:0] col_pre_ld;

    // ------------------------------------------------------------------
    // Command selection
    // ------------------------------------------------------------------
    always_comb begin
        row_hit = pending_q && (buf_ra_q == open_row_q);
        cmd_sel = CMD_NONE;
        case (state_q)
            BK_CLOSED: begin
                if (pending_q && !ref_req && rp_zero) begin
                    cmd_sel = CMD_ACT;
                end
            end
            BK_OPEN: begin
                if (row_hit && !ref_req) begin
                    // Hit: wait for tRCD, then issue the column command.
                    if (rcd_zero) begin
                        cmd_sel = buf_wr_q ? CMD_WR : CMD_RD;
                    end
                end else if ((ref_req || pending_q) && ras_zero && pre_zero) begin
                    // Row miss or refresh: close the row once tRAS and the
                    // read/write-to-precharge wait have both elapsed.
                    cmd_sel = CMD_PRE;
                end
            end
            default: cmd_sel = CMD_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fire       = cmd_gnt && (cmd_sel != CMD_NONE);
        accept     = req_valid && req_ready;
        act_load   = fire && (cmd_sel == CMD_ACT);
        col_load   = fire && ((cmd_sel == CMD_RD) || (cmd_sel == CMD_WR));
        pre_load   = fire && (cmd_sel == CMD_PRE);
        col_pre_ld = buf_wr_q ? WTP_LD : RTP_LD;

        state_d    = state_q;
        pending_d  = pending_q;
        buf_id_d   = buf_id_q;
        buf_ra_d   = buf_ra_q;
        buf_ca_d   = buf_ca_q;
        buf_len_d  = buf_len_q;
        buf_wr_d   = buf_wr_q;
        open_row_d = open_row_q;

        if (act_load) begin
            state_d    = BK_OPEN;
            open_row_d = buf_ra_q;
        end
        if (pre_load) begin
            state_d = BK_CLOSED;
        end
        // A column command completes the buffered request. accept and
        // col_load cannot coincide because req_ready needs !pending_q.
        if (col_load) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
            buf_id_d  = req_id;
            buf_ra_d  = req_ra;
            buf_ca_d  = req_ca;
            buf_len_d = req_len;
            buf_wr_d  = req_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BK_CLOSED;
            pending_q  <= 1'b0;
            buf_id_q   <= '0;
            buf_ra_q   <= '0;
            buf_ca_q   <= '0;
            buf_len_q  <= '0;
            buf_wr_q   <= 1'b0;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            buf_id_q   <= buf_id_d;
            buf_ra_q   <= buf_ra_d;
            buf_ca_q   <= buf_ca_d;
            buf_len_q  <= buf_len_d;
            buf_wr_q   <= buf_wr_d;
            open_row_q <= open_row_d;
        end
    end

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    sal_timing_cnt #(.CNT_W(CNT_W), .MAX_LOAD(1'b0)) u_rcd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (act_load),
        .load_val (RCD_LD),
        .zero     (rcd_zero)
    );

    sal_timing_cnt #(.CNT_W(CNT_W), .MAX_LOAD(1'b0)) u_ras_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (act_load),
        .load_val (RAS_LD),
        .zero     (ras_zero)
    );

    // Shared RD/WR-to-PRE wait: a short read never cuts short an earlier
    // write's recovery time.
    sal_timing_cnt #(.CNT_W(CNT_W), .MAX_LOAD(1'b1)) u_pre_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (col_load),
        .load_val (col_pre_ld),
        .zero     (pre_zero)
    );

    sal_timing_cnt #(.CNT_W(CNT_W), .MAX_LOAD(1'b0)) u_rp_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load),
        .load_val (RP_LD),
        .zero     (rp_zero)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = !pending_q && !rst;

    assign cmd_act = (cmd_sel == CMD_ACT);
    assign cmd_rd  = (cmd_sel == CMD_RD);
    assign cmd_wr  = (cmd_sel == CMD_WR);
    assign cmd_pre = (cmd_sel == CMD_PRE);

    assign cmd_ra  = (cmd_sel == CMD_PRE) ? open_row_q : buf_ra_q;
    assign cmd_ca  = buf_ca_q;
    assign cmd_id  = buf_id_q;
    assign cmd_len = buf_len_q;

    assign bk_idle   = (state_q == BK_CLOSED) && rp_zero;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sal_bank_ctrl
// Bench for sal_bank_ctrl: a directed vector table, hand-written sequences
// for refresh, grant back-pressure and mid-operation reset, then random
// traffic checked every cycle against a timestamp-based bank model.
// ---------------------------------------------------------------------------
module tb_sal_bank_ctrl;

    localparam int ID_W  = 4;
    localparam int RA_W  = 14;
    localparam int CA_W  = 10;
    localparam int LEN_W = 4;
    localparam int CNT_W = 5;
    localparam int T_RCD = 5;
    localparam int T_RP  = 5;
    localparam int T_RAS = 18;
    localparam int T_RTP = 3;
    localparam int T_WTP = 13;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_ACT  = 4'b1000;
    localparam logic [3:0] C_RD   = 4'b0100;
    localparam logic [3:0] C_WR   = 4'b0010;
    localparam logic [3:0] C_PRE  = 4'b0001;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [ID_W-1:0]  req_id;
    logic [RA_W-1:0]  req_ra;
    logic [CA_W-1:0]  req_ca;
    logic [LEN_W-1:0] req_len;
    logic             req_wr;
    logic             cmd_act, cmd_rd, cmd_wr, cmd_pre;
    logic             cmd_gnt;
    logic [RA_W-1:0]  cmd_ra;
    logic [CA_W-1:0]  cmd_ca;
    logic [ID_W-1:0]  cmd_id;
    logic [LEN_W-1:0] cmd_len;
    logic             ref_req;
    logic             bk_idle;
    logic             dbg_state;

    always #5 clk = ~clk;

    sal_bank_ctrl #(
        .ID_W(ID_W), .RA_W(RA_W), .CA_W(CA_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RTP(T_RTP), .T_WTP(T_WTP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_id    (req_id),
        .req_ra    (req_ra),
        .req_ca    (req_ca),
        .req_len   (req_len),
        .req_wr    (req_wr),
        .cmd_act   (cmd_act),
        .cmd_rd    (cmd_rd),
        .cmd_wr    (cmd_wr),
        .cmd_pre   (cmd_pre),
        .cmd_gnt   (cmd_gnt),
        .cmd_ra    (cmd_ra),
        .cmd_ca    (cmd_ca),
        .cmd_id    (cmd_id),
        .cmd_len   (cmd_len),
        .ref_req   (ref_req),
        .bk_idle   (bk_idle),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] dut_cmd();
        return {cmd_act, cmd_rd, cmd_wr, cmd_pre};
    endfunction

    // ---------------- reference model ----------------
    // The bank is described by the cycle numbers of its last ACT and PRE
    // grants plus the first cycle in which a PRE is allowed by the column
    // commands issued so far. Every rule is "cycle >= timestamp + T".
    bit               m_pending, m_open, m_wr;
    logic [RA_W-1:0]  m_ra, m_row;
    logic [CA_W-1:0]  m_ca;
    logic [ID_W-1:0]  m_id;
    logic [LEN_W-1:0] m_len;
    int               t_act, t_pre, pre_ok;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_pending = 1'b0;
        m_open    = 1'b0;
        m_row     = '0;
        m_ra      = '0;
        m_ca      = '0;
        m_id      = '0;
        m_len     = '0;
        m_wr      = 1'b0;
        t_act     = -1000;
        t_pre     = -1000;
        pre_ok    = -1000;
    endtask

    function automatic logic [3:0] model_cmd();
        bit hit;
        hit = m_pending && (m_ra == m_row);
        if (!m_open) begin
            return (m_pending && !ref_req && cyc >= t_pre + T_RP) ? C_ACT : C_NONE;
        end
        if (hit && !ref_req) begin
            if (cyc >= t_act + T_RCD) return m_wr ? C_WR : C_RD;
            return C_NONE;
        end
        if ((ref_req || m_pending) && cyc >= t_act + T_RAS && cyc >= pre_ok) return C_PRE;
        return C_NONE;
    endfunction

    task automatic model_check();
        logic [3:0]      exp_c;
        logic [RA_W-1:0] exp_ra;
        exp_c  = model_cmd();
        exp_ra = (exp_c == C_PRE) ? m_row : m_ra;
        check("cmd", dut_cmd(), exp_c);
        check("req_ready", req_ready, !m_pending && !rst);
        check("bk_idle", bk_idle, !m_open && (cyc >= t_pre + T_RP));
        check("dbg_state", dbg_state, m_open);
        if (exp_c != C_NONE)
            check("cmd_fields", {cmd_ra, cmd_ca, cmd_id, cmd_len}, {exp_ra, m_ca, m_id, m_len});
    endtask

    // Advances the model across the clock edge that ends cycle 'cyc'.
    task automatic model_update();
        logic [3:0] c;
        bit         was_pending;
        if (rst) begin
            model_reset();
        end else begin
            c           = model_cmd();
            was_pending = m_pending;
            if (cmd_gnt && c != C_NONE) begin
                case (c)
                    C_ACT: begin m_open = 1'b1; m_row = m_ra; t_act = cyc; end
                    // The PRE-wait register keeps its remaining count through
                    // the grant cycle, so an outstanding longer wait gains one.
                    C_RD:  begin m_pending = 1'b0; pre_ok = imax(pre_ok + 1, cyc + T_RTP); end
                    C_WR:  begin m_pending = 1'b0; pre_ok = imax(pre_ok + 1, cyc + T_WTP); end
                    C_PRE: begin m_open = 1'b0; t_pre = cyc; end
                    default: ;
                endcase
            end
            if (req_valid && !was_pending) begin
                m_pending = 1'b1;
                m_ra  = req_ra;
                m_ca  = req_ca;
                m_id  = req_id;
                m_len = req_len;
                m_wr  = req_wr;
            end
        end
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic sample_check();
        #3;
        model_check();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [RA_W-1:0] ra,
                           input logic [CA_W-1:0] ca, input logic [ID_W-1:0] id,
                           input logic [LEN_W-1:0] len);
        req_valid = v;
        req_wr    = w;
        req_ra    = ra;
        req_ca    = ca;
        req_id    = id;
        req_len   = len;
    endtask

    // Runs cycles (with the current inputs) until the DUT shows 'code'.
    task automatic wait_cmd(input string name, input logic [3:0] code, input int budget,
                            output int at, output int others);
        bit found;
        found  = 1'b0;
        at     = -1;
        others = 0;
        for (int k = 0; k < budget && !found; k++) begin
            sample_check();
            if (dut_cmd() == code) begin
                found = 1'b1;
                at    = cyc;
            end else if (dut_cmd() != C_NONE) begin
                others++;
            end
            edge_step();
        end
        check({"wait_", name}, found, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             vld;
        logic             wr;
        logic [RA_W-1:0]  ra;
        logic [CA_W-1:0]  ca;
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
        logic             gnt;
        int               reps;
        logic [3:0]       exp_cmd;
        logic             exp_rdy;
        logic             exp_idle;
        logic [RA_W-1:0]  exp_ra;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int act_c, pre_c, act2, rd2, oth;
        logic [RA_W-1:0] rows[4];

        // Read miss on closed bank, write hit, read miss forcing PRE/ACT.
        tbl[0]  = '{1'b1, 1'b0, 14'h12, 10'h040, 4'd3, 4'd7, 1'b1, 1,  C_NONE, 1'b1, 1'b1, 14'h0};
        tbl[1]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_ACT,  1'b0, 1'b1, 14'h12};
        tbl[2]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 4,  C_NONE, 1'b0, 1'b0, 14'h0};
        tbl[3]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_RD,   1'b0, 1'b0, 14'h12};
        tbl[4]  = '{1'b1, 1'b1, 14'h12, 10'h080, 4'd5, 4'd3, 1'b1, 1,  C_NONE, 1'b1, 1'b0, 14'h0};
        tbl[5]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_WR,   1'b0, 1'b0, 14'h12};
        tbl[6]  = '{1'b1, 1'b0, 14'h34, 10'h011, 4'd9, 4'd1, 1'b1, 1,  C_NONE, 1'b1, 1'b0, 14'h0};
        tbl[7]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 11, C_NONE, 1'b0, 1'b0, 14'h0};
        tbl[8]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_PRE,  1'b0, 1'b0, 14'h12};
        tbl[9]  = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 4,  C_NONE, 1'b0, 1'b0, 14'h0};
        tbl[10] = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_ACT,  1'b0, 1'b1, 14'h34};
        tbl[11] = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 4,  C_NONE, 1'b0, 1'b0, 14'h0};
        tbl[12] = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_RD,   1'b0, 1'b0, 14'h34};
        tbl[13] = '{1'b0, 1'b0, 14'h0,  10'h0,   4'd0, 4'd0, 1'b1, 1,  C_NONE, 1'b1, 1'b0, 14'h0};

        rows[0] = 14'h12;
        rows[1] = 14'h34;
        rows[2] = 14'h0;
        rows[3] = 14'h3FFF;

        // ---------------- reset ----------------
        model_reset();
        rst     = 1'b1;
        cmd_gnt = 1'b0;
        ref_req = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        edge_step();
        edge_step();
        sample_check();
        check("rst_ready", req_ready, 1'b0);
        check("rst_idle", bk_idle, 1'b1);
        check("rst_cmd", dut_cmd(), C_NONE);
        edge_step();
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                set_req(tbl[i].vld, tbl[i].wr, tbl[i].ra, tbl[i].ca, tbl[i].id, tbl[i].len);
                cmd_gnt = tbl[i].gnt;
                sample_check();
                check($sformatf("tbl%0d_cmd", i), dut_cmd(), tbl[i].exp_cmd);
                check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_rdy);
                check($sformatf("tbl%0d_idle", i), bk_idle, tbl[i].exp_idle);
                if (tbl[i].exp_cmd != C_NONE)
                    check($sformatf("tbl%0d_ra", i), cmd_ra, tbl[i].exp_ra);
                edge_step();
            end
        end

        // ---------------- grant withheld, then reset while OPEN ----------------
        // Row 0x34 is open with tRCD long satisfied: a hit must hold RD.
        set_req(1'b1, 1'b0, 14'h34, 10'h022, 4'hA, 4'd2);
        cmd_gnt = 1'b0;
        sample_check();
        check("hold_accept_ready", req_ready, 1'b1);
        edge_step();
        for (int k = 0; k < 20; k++) begin
            // Competing request must be ignored while the buffer is full.
            set_req(1'b1, 1'b1, 14'h56, CA_W'($urandom_range(0, 1023)), 4'h1, 4'd9);
            sample_check();
            check($sformatf("hold%0d_cmd", k), dut_cmd(), C_RD);
            check($sformatf("hold%0d_fields", k), {cmd_ra, cmd_ca, cmd_id, cmd_len},
                  {14'h34, 10'h022, 4'hA, 4'd2});
            check($sformatf("hold%0d_ready", k), req_ready, 1'b0);
            edge_step();
        end
        rst = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        sample_check();
        check("midrst_ready_low", req_ready, 1'b0);
        edge_step();
        rst = 1'b0;
        sample_check();
        check("midrst_cmd", dut_cmd(), C_NONE);
        check("midrst_idle", bk_idle, 1'b1);
        check("midrst_ready", req_ready, 1'b1);
        edge_step();

        // ---------------- refresh while OPEN with pending hit ----------------
        cmd_gnt = 1'b1;
        set_req(1'b1, 1'b0, 14'h12, 10'h003, 4'd6, 4'd4);
        sample_check();
        edge_step();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        wait_cmd("ref_act", C_ACT, 3, act_c, oth);
        ref_req = 1'b1;
        wait_cmd("ref_pre", C_PRE, 40, pre_c, oth);
        check("ref_pre_time", pre_c, act_c + T_RAS);
        check("ref_no_col", oth, 0);
        for (int k = 1; k <= T_RP; k++) begin
            sample_check();
            check($sformatf("ref_idle_%0d", k), bk_idle, (k >= T_RP));
            edge_step();
        end
        ref_req = 1'b0;
        wait_cmd("ref_act2", C_ACT, 5, act2, oth);
        check("ref_act2_time", act2, pre_c + T_RP + 1);
        wait_cmd("ref_rd", C_RD, 10, rd2, oth);
        check("ref_rd_time", rd2, act2 + T_RCD);

        // ---------------- random traffic ----------------
        begin
            int ref_left;
            ref_left = 0;
            for (int n = 0; n < 2500; n++) begin
                rst = ($urandom_range(0, 299) == 0);
                set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        rows[$urandom_range(0, 3)], CA_W'($urandom_range(0, 1023)),
                        ID_W'($urandom_range(0, 15)), LEN_W'($urandom_range(0, 15)));
                cmd_gnt = ($urandom_range(0, 9) < 7);
                if (ref_left > 0) begin
                    ref_left--;
                end else if ($urandom_range(0, 149) == 0) begin
                    ref_left = $urandom_range(10, 60);
                end
                ref_req = (ref_left > 0);
                sample_check();
                edge_step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sal_bank_ctrl.md
# sal_bank_ctrl

Per-bank DRAM controller sitting directly downstream of the address decoder: one instance per bank receives that bank's decoded request (id, row, column, length, direction), tracks the bank's open row and per-bank DDR2 timing, and raises ACT/RD/WR/PRE command requests toward the shared command scheduler. Open-page policy: the row stays open until a row miss or a refresh request forces a precharge.

## Interface
Parameters:
- ID_W, 4, AXI ID width
- RA_W, 14, row address width
- CA_W, 10, column address width
- LEN_W, 4, burst length field width
- CNT_W, 5, timing counter width
- T_RCD, 5, ACT→RD/WR cycles
- T_RP, 5, PRE→ACT cycles
- T_RAS, 18, ACT→PRE cycles
- T_RTP, 3, RD→PRE cycles
- T_WTP, 13, WR→PRE cycles (write latency + burst + tWR)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request from decoder
- req_ready  out  1  request accepted when valid&ready
- req_id  in  ID_W;  req_ra  in  RA_W;  req_ca  in  CA_W;  req_len  in  LEN_W;  req_wr  in  1 (1=write)
- cmd_act / cmd_rd / cmd_wr / cmd_pre  out  1 each  command requests, at most one high
- cmd_gnt  in  1  scheduler grant for the currently asserted command
- cmd_ra  out  RA_W;  cmd_ca  out  CA_W;  cmd_id  out  ID_W;  cmd_len  out  LEN_W  command fields
- ref_req  in  1  refresh pending; bank must close
- bk_idle  out  1  bank closed and T_RP satisfied

## Operation
- One-entry request buffer. req_ready = !pending && !rst (no gnt→ready bypass). Accept loads buffer, sets pending.
- States: CLOSED, OPEN. Registers: open_row, rcd_cnt, ras_cnt, pre_cnt (RTP/WTP), rp_cnt; each loads T−1 on its command's grant, decrements to 0, saturates at 0.
- CLOSED: cmd_act = pending && !ref_req && rp_cnt==0; cmd_ra = buffered ra. On grant: → OPEN, open_row←ra, rcd_cnt←T_RCD−1, ras_cnt←T_RAS−1.
- OPEN, hit (pending, ra==open_row, !ref_req): cmd_rd/cmd_wr (per req_wr) when rcd_cnt==0. On grant: pending←0; pre_cnt←max(pre_cnt, T_RTP−1 or T_WTP−1).
- OPEN, miss or ref_req: cmd_pre when ras_cnt==0 && pre_cnt==0. On grant: → CLOSED, rp_cnt←T_RP−1.
- cmd_* fields = buffered request (ra = open_row for PRE); stable while request held.
- cmd_gnt with no command asserted is ignored. Requests may wait indefinitely; no timeout.
- ref_req blocks new ACT/RD/WR; a buffered request waits and is served after ref_req drops.
- bk_idle = CLOSED && rp_cnt==0 (independent of pending).
- Timing parameters must satisfy 1 ≤ T ≤ 2^CNT_W−1.

## Timing
- Reset: state CLOSED, pending 0, all counters 0, open_row 0; all cmd_* 0, bk_idle 1 after reset cycle; req_ready 0 during rst. rst mid-operation discards buffer and row state next edge.
- Accept in cycle n → cmd_act earliest cycle n+1.
- ACT granted cycle n → RD/WR earliest n+T_RCD, PRE earliest n+T_RAS.
- RD granted cycle n → PRE earliest n+T_RTP; WR → n+T_WTP.
- PRE granted cycle n → ACT earliest n+T_RP; bk_idle high from n+T_RP.
- Next request acceptable the cycle after RD/WR grant (max 1 request / 2 cycles).
- Commands are level requests; scheduler samples fields in grant cycle.

## Structure
- Shared package sal_ddr2_pkg: bank state enum, command enum, default DDR2-800 timing constants.
- Sub-module sal_timing_cnt (load T−1, decrement, saturating zero flag) instantiated four times.

## Test plan
- Read miss on CLOSED bank, T_RCD=5, gnt immediate: ACT in cycle 1, RD in cycle 6, id/ca match request.
- Two reads row 0x12, same bank: one ACT, two RDs, no PRE.
- Write row 0x12 then read row 0x34: PRE no earlier than WR grant+13 and ACT grant+18; ACT row 0x34 at PRE grant+5.
- ref_req asserted while OPEN with pending hit: no RD; PRE after tRAS; bk_idle at PRE grant+T_RP; RD served after ref_req drops (ACT then RD).
- Scheduler withholds cmd_gnt 20 cycles: command and fields stable, req_ready stays 0.
- rst pulsed while OPEN with pending request: next cycle all cmd_* 0, bk_idle 1, req_ready 1 after rst release.
